mp3_bus_sched: RTL

MP3_BUS_SCHED -- requirements
Module: mp3_bus_sched

---
 rtl/mp3_bus_sched.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/mp3_bus_sched.sv
`timescale 1ns/1ps
// mp3_bus_sched: arbitrates an SCI command requester and an SDI data requester
// onto the shared VS10xx-style serial bus. Each 32-bit word is shifted MSB-first
// once MP3_DREQ is high; a word, once started, is always sent in full.
// Optional feature: define MP3_BUS_SCHED_SCI_READBACK_EN to capture MP3_MISO
// during SCI read transfers (opcode 8'h03) into rdata.
module mp3_bus_sched #(
  parameter int SCLK_DIV  = 2,
  parameter int CMD_BURST = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        cmd_valid,
  input  logic [31:0] cmd_word,
  output logic        cmd_ready,
  input  logic        dat_valid,
  input  logic [31:0] dat_word,
  output logic        dat_ready,
  output logic        MP3_CS,
  output logic        MP3_DCS,
  output logic        MP3_MOSI,
  output logic        MP3_SCLK,
  input  logic        MP3_MISO,
  input  logic        MP3_DREQ,
  output logic        busy,
  output logic        done,
  output logic        done_is_cmd,
  output logic [15:0] rdata
);
  localparam int BW = (CMD_BURST < 1) ? 1 : $clog2(CMD_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(CMD_BURST);
  localparam logic [7:0]    DIV_LAST  = 8'(SCLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, WAIT_DREQ, SHIFT, GAP} state_t;

  state_t          state_reg, state_next;
  logic [31:0]     word_reg, word_next;
  logic            kind_reg, kind_next;          // 1 = SCI, 0 = SDI
  logic [7:0]      div_reg, div_next;
  logic [5:0]      rise_reg, rise_next;          // SCLK rising edges so far
  logic            sclk_reg, sclk_next;
  logic            mosi_reg, mosi_next;
  logic            cs_reg, cs_next;
  logic            dcs_reg, dcs_next;
  logic            busy_reg, busy_next;
  logic            done_reg, done_next;
  logic            done_is_cmd_reg, done_is_cmd_next;
  logic [BW-1:0]   burst_reg, burst_next;
  logic            grant_cmd;

  // SCI wins unless SDI is waiting and the command burst allowance is used up.
  // Ready is combinational so the accept cycle is the cycle ready is seen high.
  assign grant_cmd = cmd_valid && (!dat_valid || (burst_reg < BURST_MAX));
  assign cmd_ready = !RST && (state_reg == IDLE) && grant_cmd;
  assign dat_ready = !RST && (state_reg == IDLE) && !grant_cmd && dat_valid;

  assign MP3_CS      = cs_reg;
  assign MP3_DCS     = dcs_reg;
  assign MP3_MOSI    = mosi_reg;
  assign MP3_SCLK    = sclk_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign done_is_cmd = done_is_cmd_reg;

  // State and bus register update; reset aborts any transfer in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg       <= IDLE;
      word_reg        <= '0;
      kind_reg        <= 1'b0;
      div_reg         <= '0;
      rise_reg        <= '0;
      sclk_reg        <= 1'b0;
      mosi_reg        <= 1'b0;
      cs_reg          <= 1'b1;
      dcs_reg         <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      done_is_cmd_reg <= 1'b0;
      burst_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      word_reg        <= word_next;
      kind_reg        <= kind_next;
      div_reg         <= div_next;
      rise_reg        <= rise_next;
      sclk_reg        <= sclk_next;
      mosi_reg        <= mosi_next;
      cs_reg          <= cs_next;
      dcs_reg         <= dcs_next;
      busy_reg        <= busy_next;
      done_reg        <= done_next;
      done_is_cmd_reg <= done_is_cmd_next;
      burst_reg       <= burst_next;
    end
  end

  // Next-state logic: grant, wait for DREQ, shift 32 bits, inter-word gap.
  always_comb begin
    state_next       = state_reg;
    word_next        = word_reg;
    kind_next        = kind_reg;
    div_next         = div_reg;
    rise_next        = rise_reg;
    sclk_next        = sclk_reg;
    mosi_next        = mosi_reg;
    cs_next          = cs_reg;
    dcs_next         = dcs_reg;
    busy_next        = busy_reg;
    done_next        = 1'b0;
    done_is_cmd_next = done_is_cmd_reg;
    burst_next       = burst_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_ready) begin
          word_next  = cmd_word;
          kind_next  = 1'b1;
          busy_next  = 1'b1;
          state_next = WAIT_DREQ;
          if (!dat_valid)
            burst_next = '0;
          else if (burst_reg != BURST_MAX)
            burst_next = burst_reg + BW'(1);
        end else if (dat_ready) begin
          word_next  = dat_word;
          kind_next  = 1'b0;
          busy_next  = 1'b1;
          burst_next = '0;
          state_next = WAIT_DREQ;
        end
      end
      WAIT_DREQ: begin
        if (MP3_DREQ) begin
          cs_next    = !kind_reg;
          dcs_next   = kind_reg;
          mosi_next  = word_reg[31];
          word_next  = {word_reg[30:0], 1'b0};
          div_next   = '0;
          rise_next  = '0;
          sclk_next  = 1'b0;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // DREQ is deliberately ignored here: a started word always completes.
        if (div_reg == DIV_LAST) begin
          div_next  = '0;
          sclk_next = !sclk_reg;
          if (!sclk_reg) begin
            rise_next = rise_reg + 6'd1;
          end else if (rise_reg == 6'd32) begin
            cs_next    = 1'b1;
            dcs_next   = 1'b1;
            mosi_next  = 1'b0;
            state_next = GAP;
          end else begin
            mosi_next = word_reg[31];
            word_next = {word_reg[30:0], 1'b0};
          end
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      GAP: begin
        if (div_reg == DIV_LAST) begin
          done_next        = 1'b1;
          done_is_cmd_next = kind_reg;
          busy_next        = 1'b0;
          state_next       = IDLE;
        end else begin
          div_next = div_reg + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef MP3_BUS_SCHED_SCI_READBACK_EN
  logic        rb_reg, rb_next;                 // current transfer is an SCI read
  logic [15:0] rd_sh_reg, rd_sh_next;
  logic [15:0] rdata_reg, rdata_next;
  logic        rise_evt, gap_exit;

  assign rise_evt = (state_reg == SHIFT) && (div_reg == DIV_LAST) && !sclk_reg;
  assign gap_exit = (state_reg == GAP) && (div_reg == DIV_LAST);
  assign rdata    = rdata_reg;

  // Readback registers; cleared with the rest of the block on reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rb_reg    <= 1'b0;
      rd_sh_reg <= '0;
      rdata_reg <= '0;
    end else begin
      rb_reg    <= rb_next;
      rd_sh_reg <= rd_sh_next;
      rdata_reg <= rdata_next;
    end
  end

  // Shift MISO in on rising edges 17..32 of a read; publish it with done.
  always_comb begin
    rb_next    = rb_reg;
    rd_sh_next = rd_sh_reg;
    rdata_next = rdata_reg;
    if (cmd_ready)
      rb_next = (cmd_word[31:24] == 8'h03);
    else if (dat_ready)
      rb_next = 1'b0;
    if (rise_evt && rb_reg && (rise_reg >= 6'd16))
      rd_sh_next = {rd_sh_reg[14:0], MP3_MISO};
    if (gap_exit && rb_reg)
      rdata_next = rd_sh_reg;
  end
`else
  logic unused_miso;
  assign unused_miso = MP3_MISO;
  assign rdata       = '0;
`endif

endmodule
